motor_pwm_sequencer: RTL
========================

Name: motor_pwm_sequencer

Overview:
- Converts the 3-bit drive command and speed multiplier produced by the robot's drive decision logic into left/right motor PWM and direction signals.
- Ramps duty in fixed steps and sequences direction reversals through ramp-down, dead-time, re-direct and ramp-up, so the H-bridge never sees a hard reversal.
- Adds a command watchdog that stops both motors if the command stream goes silent.
- Sits between the drive decision block and the motor driver pins.

Parameters:
PWM_BITS, 8, duty/PWM counter width
PRESCALE, 195, clk cycles per PWM counter increment
BASE_DUTY, 64, duty per multiplier unit
RAMP_STEP_CYCLES, 500000, clk cycles between ramp steps
RAMP_INC, 8, duty change per ramp step
DEADTIME_CYCLES, 2500000, zero-drive hold before a direction flip
WATCHDOG_CYCLES, 25000000, max clk cycles without cmd_valid

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
drive_command  in  3  0 Stop, 1 TurnLeft, 2 Left, 3 Straight, 4 Right, 5 TurnRight, 6-7 Stop
multiplier  in  3  speed multiplier
cmd_valid  in  1  command/multiplier valid strobe (may be held high)
left_pwm  out  1  left motor PWM
right_pwm  out  1  right motor PWM
left_dir  out  1  1 = forward
right_dir  out  1  1 = forward
left_duty  out  PWM_BITS  current left duty
right_duty  out  PWM_BITS  current right duty
settled  out  1  both wheels at target duty and direction
fault  out  1  watchdog expired

Behaviour:
- One clock: clk. Reset is synchronous, active-high.
- Reset values, applied on the cycle after reset is sampled high and independent of the current state (including mid-ramp and mid-dead-time):
  - duties 0; pwm outputs 0; dirs 1; fault 0; settled 1.
  - latched command Stop; all counters 0; both channel FSMs in RUN.
- Command latch: on cmd_valid, drive_command and multiplier are registered at N+1 and the watchdog is cleared.
- Target duty:
  - T = BASE_DUTY*multiplier, saturated to 2^PWM_BITS-1. Compute at PWM_BITS+3 width, then clamp.
  - multiplier 0 gives T = 0.
- Per-wheel targets as (dir, duty):
  - Stop / 6 / 7: both 0.
  - TurnLeft: L (0,T), R (1,T).
  - Left: L (1,T>>1), R (1,T).
  - Straight: both (1,T).
  - Right: L (1,T), R (1,T>>1).
  - TurnRight: L (1,T), R (0,T).
- Immediate stop:
  - Triggered when the latched command is Stop/6/7 or fault = 1.
  - Both duties, shadow duties and pwm outputs are 0 at N+2, bypassing the ramp.
  - Channel FSM goes to RUN; dir is unchanged.
- Ramp tick: a shared counter pulses one cycle every RAMP_STEP_CYCLES; it free-runs from reset.
- Channel FSM, identical for each wheel:
  - RUN, dir equals target dir: on each tick, duty moves toward target by RAMP_INC, clamped so it never overshoots.
  - RUN, dir differs from target dir and target > 0: the ramp goal is 0. When duty = 0, go to DEAD and load DEADTIME_CYCLES.
  - DEAD: pwm forced 0; counter decrements. At expiry, dir <= target dir and return to RUN; ramp-up starts from 0 on the next tick.
  - DEAD re-targeting: if the target dir returns to the current dir while in DEAD, the dead-time still completes.
  - Target changing mid-ramp: the goal is re-evaluated every tick.
- PWM generation:
  - pwm_cnt advances every PRESCALE cycles and wraps from 2^PWM_BITS-1 to 0.
  - Shadow duty is loaded from duty only when pwm_cnt = 0 and the prescaler fires, giving glitch-free periods.
  - pwm = (pwm_cnt < shadow), so duty 255 gives 255/256 high and duty 0 gives constant low.
  - Immediate stop overrides the shadow.
- Watchdog:
  - The counter increments on every cycle without cmd_valid.
  - On reaching WATCHDOG_CYCLES: fault <= 1 and the latched command is forced to Stop.
  - fault clears on the next cmd_valid, which latches normally.
  - cmd_valid on the same cycle as expiry: cmd_valid wins and no fault is raised.
- settled = 1 when both channels are in RUN with duty = target duty and dir = target dir (registered).

Test Plan (PRESCALE=1, RAMP_STEP_CYCLES=4, RAMP_INC=16, DEADTIME_CYCLES=10, WATCHDOG_CYCLES=100, BASE_DUTY=64, cmd_valid held high unless stated):
- Reset, then Straight with mult 3 -> both duties step 16,32,…,192, one step per 4 cycles (12 ticks); settled = 1 after that; each pwm is high for 192 of every 256 cycles; dirs = 1.
- Settled Straight 192, then TurnLeft -> left ramps 192→0, then left_pwm low for exactly 10 cycles with left_dir = 1, then left_dir = 0 and ramp to 192; right stays at 192 forward throughout; settled only at the end.
- Running at 192, Stop -> both duties 0 and both pwm 0 two cycles after cmd_valid; dirs unchanged.
- Right with mult 5 -> T saturates to 255 (not 320): left duty 255, right duty 127; command 7 -> immediate stop; mult 0 -> both duties 0.
- Running Straight, then cmd_valid dropped for 100 cycles -> fault = 1 and duties 0 at expiry; cmd_valid with Straight clears fault and ramp restarts from 0; cmd_valid on the expiry cycle -> fault stays 0.
- reset asserted mid-DEAD (left reversing) -> next cycle all outputs at reset values and FSM in RUN; after release with Straight mult 1 -> ramps to 64 with dirs = 1.

Source files
------------

// File: rtl/motor_pwm_sequencer.sv
// Left/right motor PWM sequencer: ramped duty, dead-timed direction reversal and a
// command watchdog between the drive decision logic and the H-bridge pins.
module motor_pwm_sequencer #(
    parameter int unsigned PWM_BITS         = 8,
    parameter int unsigned PRESCALE         = 195,
    parameter int unsigned BASE_DUTY        = 64,
    parameter int unsigned RAMP_STEP_CYCLES = 500000,
    parameter int unsigned RAMP_INC         = 8,
    parameter int unsigned DEADTIME_CYCLES  = 2500000,
    parameter int unsigned WATCHDOG_CYCLES  = 25000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          drive_command,
    input  logic [2:0]          multiplier,
    input  logic                cmd_valid,
    output logic                left_pwm,
    output logic                right_pwm,
    output logic                left_dir,
    output logic                right_dir,
    output logic [PWM_BITS-1:0] left_duty,
    output logic [PWM_BITS-1:0] right_duty,
    output logic                settled,
    output logic                fault
);

    localparam int unsigned ProdW  = PWM_BITS + 3;
    localparam int unsigned PreW   = $clog2(PRESCALE + 1);
    localparam int unsigned RampW  = $clog2(RAMP_STEP_CYCLES + 1);
    localparam int unsigned DeadW  = $clog2(DEADTIME_CYCLES + 1);
    localparam int unsigned WdW    = $clog2(WATCHDOG_CYCLES + 1);

    localparam logic [ProdW-1:0]    BaseW     = ProdW'(BASE_DUTY);
    localparam logic [PWM_BITS-1:0] DutyMax   = '1;
    localparam logic [PWM_BITS-1:0] RampInc   = PWM_BITS'(RAMP_INC);
    localparam logic [PreW-1:0]     PreLast   = PreW'(PRESCALE - 1);
    localparam logic [RampW-1:0]    RampLast  = RampW'(RAMP_STEP_CYCLES - 1);
    localparam logic [DeadW-1:0]    DeadLoad  = DeadW'(DEADTIME_CYCLES);
    localparam logic [WdW-1:0]      WdLast    = WdW'(WATCHDOG_CYCLES - 1);

    localparam logic [2:0] CmdStop      = 3'd0;
    localparam logic [2:0] CmdTurnLeft  = 3'd1;
    localparam logic [2:0] CmdLeft      = 3'd2;
    localparam logic [2:0] CmdStraight  = 3'd3;
    localparam logic [2:0] CmdRight     = 3'd4;
    localparam logic [2:0] CmdTurnRight = 3'd5;

    typedef enum logic {StRun, StDead} ch_state_e;

    logic [2:0]          cmd_q, cmd_d, mult_q, mult_d;
    logic [WdW-1:0]      wd_q, wd_d;
    logic                fault_q, fault_d;
    logic [RampW-1:0]    ramp_q, ramp_d;
    logic [PreW-1:0]     pre_q, pre_d;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                settled_q, settled_d;
    logic                tick, pre_fire, stop;

    ch_state_e           st_q [2], st_d [2];
    logic [PWM_BITS-1:0] duty_q [2], duty_d [2], shadow_q [2], shadow_d [2];
    logic [DeadW-1:0]    dead_q [2], dead_d [2];
    logic                dir_q [2], dir_d [2], pwm_q [2], pwm_d [2];
    logic [PWM_BITS-1:0] tgt_duty [2];
    logic                tgt_dir [2], req_dir [2];
    logic [ProdW-1:0]    prod;
    logic [PWM_BITS-1:0] t_full, t_half;

    function automatic logic [PWM_BITS-1:0] step_toward(input logic [PWM_BITS-1:0] cur,
                                                        input logic [PWM_BITS-1:0] goal);
        if (cur < goal) begin
            return (goal - cur > RampInc) ? cur + RampInc : goal;
        end else if (cur > goal) begin
            return (cur - goal > RampInc) ? cur - RampInc : goal;
        end
        return cur;
    endfunction

    always_comb begin
        cmd_d   = cmd_q;
        mult_d  = mult_q;
        fault_d = fault_q;
        wd_d    = wd_q;
        if (cmd_valid) begin
            cmd_d   = drive_command;
            mult_d  = multiplier;
            fault_d = 1'b0;
            wd_d    = '0;
        end else begin
            if (wd_q != WdLast + 1'b1) wd_d = wd_q + 1'b1;
            if (wd_q == WdLast) begin
                fault_d = 1'b1;
                cmd_d   = CmdStop;
            end
        end
        tick     = (ramp_q == RampLast);
        ramp_d   = tick ? '0 : ramp_q + 1'b1;
        pre_fire = (pre_q == PreLast);
        pre_d    = pre_fire ? '0 : pre_q + 1'b1;
        cnt_d    = pre_fire ? cnt_q + 1'b1 : cnt_q;
    end

    always_comb begin
        prod   = BaseW * ProdW'(mult_q);
        t_full = (prod > ProdW'(DutyMax)) ? DutyMax : prod[PWM_BITS-1:0];
        t_half = t_full >> 1;
        stop   = fault_q || (cmd_q == CmdStop) || (cmd_q > CmdTurnRight);
        tgt_duty[0] = '0;
        tgt_duty[1] = '0;
        req_dir[0]  = 1'b1;
        req_dir[1]  = 1'b1;
        case (cmd_q)
            CmdTurnLeft:  begin tgt_duty[0] = t_full; tgt_duty[1] = t_full; req_dir[0] = 1'b0; end
            CmdLeft:      begin tgt_duty[0] = t_half; tgt_duty[1] = t_full; end
            CmdStraight:  begin tgt_duty[0] = t_full; tgt_duty[1] = t_full; end
            CmdRight:     begin tgt_duty[0] = t_full; tgt_duty[1] = t_half; end
            CmdTurnRight: begin tgt_duty[0] = t_full; tgt_duty[1] = t_full; req_dir[1] = 1'b0; end
            default: ;
        endcase
        // A wheel with zero target has no reason to reverse.
        for (int i = 0; i < 2; i++) begin
            tgt_dir[i] = (tgt_duty[i] == '0) ? dir_q[i] : req_dir[i];
        end
    end

    always_comb begin
        settled_d = 1'b1;
        for (int i = 0; i < 2; i++) begin
            st_d[i]     = st_q[i];
            duty_d[i]   = duty_q[i];
            dir_d[i]    = dir_q[i];
            dead_d[i]   = dead_q[i];
            shadow_d[i] = shadow_q[i];
            if (stop) begin
                st_d[i]   = StRun;
                duty_d[i] = '0;
                dead_d[i] = '0;
            end else if (st_q[i] == StDead) begin
                if (dead_q[i] <= DeadW'(1)) begin
                    st_d[i]   = StRun;
                    dir_d[i]  = tgt_dir[i];
                    dead_d[i] = '0;
                end else begin
                    dead_d[i] = dead_q[i] - 1'b1;
                end
            end else if (dir_q[i] == tgt_dir[i]) begin
                if (tick) duty_d[i] = step_toward(duty_q[i], tgt_duty[i]);
            end else begin
                // Reversal: ramp to zero, entering dead-time on the edge duty reaches zero.
                if (tick) duty_d[i] = step_toward(duty_q[i], '0);
                if (duty_d[i] == '0) begin
                    st_d[i]   = StDead;
                    dead_d[i] = DeadLoad;
                end
            end
            if (stop) begin
                shadow_d[i] = '0;
            end else if (pre_fire && cnt_q == '0) begin
                shadow_d[i] = duty_q[i];
            end
            pwm_d[i] = !stop && (st_d[i] != StDead) && (cnt_d < shadow_d[i]);
            if (st_q[i] != StRun || duty_q[i] != tgt_duty[i] || dir_q[i] != tgt_dir[i]) begin
                settled_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q     <= CmdStop;
            mult_q    <= '0;
            wd_q      <= '0;
            fault_q   <= 1'b0;
            ramp_q    <= '0;
            pre_q     <= '0;
            cnt_q     <= '0;
            settled_q <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                st_q[i]     <= StRun;
                duty_q[i]   <= '0;
                shadow_q[i] <= '0;
                dead_q[i]   <= '0;
                dir_q[i]    <= 1'b1;
                pwm_q[i]    <= 1'b0;
            end
        end else begin
            cmd_q     <= cmd_d;
            mult_q    <= mult_d;
            wd_q      <= wd_d;
            fault_q   <= fault_d;
            ramp_q    <= ramp_d;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            settled_q <= settled_d;
            for (int i = 0; i < 2; i++) begin
                st_q[i]     <= st_d[i];
                duty_q[i]   <= duty_d[i];
                shadow_q[i] <= shadow_d[i];
                dead_q[i]   <= dead_d[i];
                dir_q[i]    <= dir_d[i];
                pwm_q[i]    <= pwm_d[i];
            end
        end
    end

    assign left_pwm   = pwm_q[0];
    assign right_pwm  = pwm_q[1];
    assign left_dir   = dir_q[0];
    assign right_dir  = dir_q[1];
    assign left_duty  = duty_q[0];
    assign right_duty = duty_q[1];
    assign settled    = settled_q;
    assign fault      = fault_q;

endmodule
